// File: rtl/ysyx_25060170_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// No logic here: fetch FSM encoding, reset PC and reset instruction word.
package ysyx_25060170_pkg;

  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ysyx_25060170_reg.sv
// Enabled register with parameterised width and reset value.
// One cycle latency from d_i to q_o when en_i is high; no backpressure.
module ysyx_25060170_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= RESET_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/ysyx_25060170_ifu_fetch.sv
// Fetch stage: one request per instruction, 3 cycles/inst best case, no prefetch.
// Request held stable until imem_req_ready; decode output held until id_ready.
module ysyx_25060170_ifu_fetch
  import ysyx_25060170_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [31:0]       imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_pc,
  output logic [INST_W-1:0] id_inst
);

  fetch_state_e      state_q, state_d;
  logic              kill_q, kill_d;
  logic              id_valid_q, id_valid_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       req_addr_q, req_addr_d;
  logic [31:0]       id_pc_q;
  logic [INST_W-1:0] id_inst_q;
  logic              id_en;
  logic [31:0]       target;
  logic [31:0]       pc_plus4;

  assign target   = redirect_pc & ~32'd3;
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      kill_q     <= 1'b0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      id_valid_q <= id_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    id_valid_d = id_valid_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    id_en      = 1'b0;
    case (state_q)
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
        // The request already on the bus goes out as is; its answer is stale.
        if (redirect_valid) kill_d = 1'b1;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (kill_q || redirect_valid) begin
            kill_d     = 1'b0;
            req_addr_d = redirect_valid ? target : pc_q;
            state_d    = S_REQ;
          end else begin
            id_en      = 1'b1;
            id_valid_d = 1'b1;
            state_d    = S_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          id_valid_d = 1'b0;
          req_addr_d = target;
          state_d    = S_REQ;
        end else if (id_ready) begin
          id_valid_d = 1'b0;
          pc_d       = pc_plus4;
          req_addr_d = pc_plus4;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    if (redirect_valid) pc_d = target;
  end

  ysyx_25060170_reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst_n), .en_i(1'b1), .d_i(pc_d), .q_o(pc_q)
  );

  ysyx_25060170_reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_req_addr (
    .clk(clk), .rst_n(rst_n), .en_i(1'b1), .d_i(req_addr_d), .q_o(req_addr_q)
  );

  ysyx_25060170_reg #(.WIDTH(32), .RESET_VAL(32'h0)) u_id_pc (
    .clk(clk), .rst_n(rst_n), .en_i(id_en), .d_i(req_addr_q), .q_o(id_pc_q)
  );

  ysyx_25060170_reg #(.WIDTH(INST_W), .RESET_VAL(NOP_INST)) u_id_inst (
    .clk(clk), .rst_n(rst_n), .en_i(id_en), .d_i(imem_resp_data), .q_o(id_inst_q)
  );

  assign imem_req_valid = (state_q == S_REQ) && rst_n;
  assign imem_req_addr  = req_addr_q;
  assign id_valid       = id_valid_q;
  assign id_pc          = id_pc_q;
  assign id_inst        = id_inst_q;

endmodule
